// File: rtl/axi_ram_slave.sv
// ---------------------------------------------------------------------------
// axi_ram_slave
// AXI4 slave that serves write and read bursts from a single-port synchronous
// RAM, one transaction at a time. Used as an on-chip external-memory model.
//
// Ports
//   clk_i, cke_i, arst_n_i        clock, clock enable (0 freezes everything),
//                                 asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*         AXI4 write address / data / response
//   axi_ar*/axi_r*                AXI4 read address / data
//   mem_en_o, mem_wstrb_o,        RAM port: strobe, byte enables (0 = read),
//   mem_addr_o, mem_wdata_o       word address, write data
//   mem_rdata_i                   RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module axi_ram_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH = 8,
  parameter int MEM_ADDR_W   = 12
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic [AXI_ID_WIDTH-1:0] axi_awid_i,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
  input  logic [7:0]              axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
  input  logic [STRB_WIDTH-1:0]   axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_WIDTH-1:0] axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
  input  logic [7:0]              axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
  output logic [DATA_WIDTH-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic                    mem_en_o,
  output logic [STRB_WIDTH-1:0]   mem_wstrb_o,
  output logic [MEM_ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BYTE_LSB = $clog2(STRB_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RWAIT, S_RDATA} state_t;

  state_t                  state_q, state_d;
  logic                    prio_rd_q, prio_rd_d;
  logic [AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    fixed_q, fixed_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rlast_q, rlast_d;

  logic [MEM_ADDR_W-1:0]   aw_word, ar_word, addr_next;
  logic                    last_beat;

  // axsize and the address bits outside the RAM window are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{axi_awsize_i, axi_arsize_i,
                       axi_awaddr_i[ADDR_WIDTH-1:MEM_ADDR_W+BYTE_LSB], axi_awaddr_i[BYTE_LSB-1:0],
                       axi_araddr_i[ADDR_WIDTH-1:MEM_ADDR_W+BYTE_LSB], axi_araddr_i[BYTE_LSB-1:0]};

  assign aw_word   = axi_awaddr_i[MEM_ADDR_W+BYTE_LSB-1:BYTE_LSB];
  assign ar_word   = axi_araddr_i[MEM_ADDR_W+BYTE_LSB-1:BYTE_LSB];
  // INCR and WRAP both simply increment; the word address wraps at RAM depth.
  assign addr_next = fixed_q ? addr_q : addr_q + 1'b1;
  assign last_beat = (cnt_q == len_q);

  // Payload outputs come straight from registers so they stay stable under back-pressure.
  assign axi_bid_o   = id_q;
  assign axi_bresp_o = {err_q, 1'b0};
  assign axi_rid_o   = id_q;
  assign axi_rdata_o = rdata_q;
  assign axi_rresp_o = 2'b00;
  assign axi_rlast_o = rlast_q;

  always_comb begin
    state_d       = state_q;
    prio_rd_d     = prio_rd_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    fixed_d       = fixed_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    rlast_d       = rlast_q;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_rvalid_o  = 1'b0;
    mem_en_o      = 1'b0;
    mem_wstrb_o   = '0;
    mem_addr_o    = addr_q;
    mem_wdata_o   = axi_wdata_i;

    // With the clock disabled nothing may handshake, so every ready/valid stays low.
    if (cke_i) begin
      unique case (state_q)
        S_IDLE: begin
          // Round-robin between AW and AR; the two readies are never both high
          // while both valids are asserted.
          axi_awready_o = ~axi_arvalid_i | ~prio_rd_q;
          axi_arready_o = ~axi_awvalid_i | prio_rd_q;
          if (axi_awvalid_i && axi_awready_o) begin
            id_d      = axi_awid_i;
            addr_d    = aw_word;
            len_d     = axi_awlen_i;
            fixed_d   = (axi_awburst_i == 2'b00);
            cnt_d     = 8'd0;
            err_d     = 1'b0;
            prio_rd_d = 1'b1;
            state_d   = S_WDATA;
          end else if (axi_arvalid_i && axi_arready_o) begin
            id_d       = axi_arid_i;
            addr_d     = ar_word;
            len_d      = axi_arlen_i;
            fixed_d    = (axi_arburst_i == 2'b00);
            cnt_d      = 8'd0;
            prio_rd_d  = 1'b0;
            mem_en_o   = 1'b1;
            mem_addr_o = ar_word;
            state_d    = S_RWAIT;
          end
        end
        S_WDATA: begin
          axi_wready_o = 1'b1;
          if (axi_wvalid_i) begin
            mem_en_o    = 1'b1;
            mem_wstrb_o = axi_wstrb_i;
            addr_d      = addr_next;
            cnt_d       = cnt_q + 8'd1;
            // Length comes from awlen; a misplaced wlast only flags SLVERR.
            if (axi_wlast_i != last_beat) err_d = 1'b1;
            if (last_beat) state_d = S_WRESP;
          end
        end
        S_WRESP: begin
          axi_bvalid_o = 1'b1;
          if (axi_bready_i) state_d = S_IDLE;
        end
        S_RWAIT: begin
          rdata_d = mem_rdata_i;
          rlast_d = last_beat;
          state_d = S_RDATA;
        end
        S_RDATA: begin
          axi_rvalid_o = 1'b1;
          if (axi_rready_i) begin
            if (rlast_q) begin
              state_d = S_IDLE;
            end else begin
              // Prefetch the next beat while the current one is accepted.
              mem_en_o   = 1'b1;
              mem_addr_o = addr_next;
              addr_d     = addr_next;
              cnt_d      = cnt_q + 8'd1;
              state_d    = S_RWAIT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= S_IDLE;
      prio_rd_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
    end
  end

endmodule
